regfile_mp: RTL and testbench

Parametrised multi-port register file for the pipelined MIPS datapath, succeeding the fixed 32x32, 2-read/1-write register file. Depth, data width, read-port count and write-port count are configurable. Entry 0 can be hardwired to zero. Optional same-cycle write-to-read bypass removes the write-back-to-decode forwarding stage. Sits between the decode stage (read ports) and the write-back stage (write ports); extra write ports serve a second issue slot or a load-return path.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_wr_sel.sv | 35 +++
 rtl/regfile_mp.sv | 108 ++++++++++
 tb/tb_regfile_mp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared limits, default widths and the packed-bus slicing helper for the
// multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_NRD    = 4;
  localparam int MAX_NWR    = 2;

  // Ports are packed side by side, so port k starts at k*width.
  function automatic int slice_off(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_wr_sel.sv
// Priority write select for one address: reports whether any enabled write
// port targets it and, if so, the data of the highest-index such port.
module regfile_wr_sel
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]     addr,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);

  logic zero_drop;

  // Writes to a hardwired-zero entry never count as a hit.
  assign zero_drop = (ZERO_REG != 0) && (addr == '0);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < NWR; k++) begin
      if (we[k] && !zero_drop && (waddr[slice_off(k, ADDR_W) +: ADDR_W] == addr)) begin
        hit  = 1'b1;
        data = wdata[slice_off(k, DATA_W) +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional zero register and
// same-cycle write-to-read bypass; flags same-address write collisions.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic                  wr_collide
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (NRD < 1 || NRD > MAX_NRD || NWR < 1 || NWR > MAX_NWR) begin : g_bad_params
    $error("regfile_mp: NRD must be 1..%0d and NWR 1..%0d", MAX_NRD, MAX_NWR);
  end

  logic [DATA_W-1:0] mem      [DEPTH];
  logic [DEPTH-1:0]  ent_hit;
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [NRD-1:0]    byp_hit;
  logic [DATA_W-1:0] byp_data [NRD];
  logic              collide_now;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    regfile_wr_sel #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NWR     (NWR),
      .ZERO_REG(ZERO_REG)
    ) u_sel (
      .we   (we),
      .waddr(waddr),
      .wdata(wdata),
      .addr (ADDR_W'(gi)),
      .hit  (ent_hit[gi]),
      .data (ent_data[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ent_hit[e]) mem[e] <= ent_data[e];
      end
    end
  end

  // The same selector, keyed by each read address, yields the bypass value.
  for (genvar gj = 0; gj < NRD; gj++) begin : g_rport
    regfile_wr_sel #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NWR     (NWR),
      .ZERO_REG(ZERO_REG)
    ) u_byp (
      .we   (we),
      .waddr(waddr),
      .wdata(wdata),
      .addr (raddr[slice_off(gj, ADDR_W) +: ADDR_W]),
      .hit  (byp_hit[gj]),
      .data (byp_data[gj])
    );
  end

  // Reset forces reads to zero so bypassed write data cannot leak out.
  always_comb begin
    rdata = '0;
    ra    = '0;
    rd    = '0;
    for (int j = 0; j < NRD; j++) begin
      ra = raddr[slice_off(j, ADDR_W) +: ADDR_W];
      rd = mem[ra];
      if ((BYPASS != 0) && byp_hit[j]) rd = byp_data[j];
      if (rst || ((ZERO_REG != 0) && (ra == '0))) rd = '0;
      rdata[slice_off(j, DATA_W) +: DATA_W] = rd;
    end
  end

  if (NWR >= 2) begin : g_collide
    assign collide_now = we[0] && we[1]
                         && (waddr[0 +: ADDR_W] == waddr[ADDR_W +: ADDR_W])
                         && !((ZERO_REG != 0) && (waddr[0 +: ADDR_W] == '0));
  end else begin : g_no_collide
    assign collide_now = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_collide <= 1'b0;
    else     wr_collide <= collide_now;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance without bypass but with a zero
// register and four read ports, one with bypass and an ordinary entry 0.
module tb_regfile_mp;

  logic         clk;
  logic         rst;

  logic [1:0]   a_we;
  logic [9:0]   a_waddr;
  logic [63:0]  a_wdata;
  logic [19:0]  a_raddr;
  logic [127:0] a_rdata;
  logic         a_col;

  logic [1:0]   b_we;
  logic [9:0]   b_waddr;
  logic [63:0]  b_wdata;
  logic [9:0]   b_raddr;
  logic [63:0]  b_rdata;
  logic         b_col;

  int compared   = 0;
  int mismatched = 0;

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NRD(4), .NWR(2), .BYPASS(0), .ZERO_REG(1)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .we        (a_we),
    .waddr     (a_waddr),
    .wdata     (a_wdata),
    .raddr     (a_raddr),
    .rdata     (a_rdata),
    .wr_collide(a_col)
  );

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(0)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .we        (b_we),
    .waddr     (b_waddr),
    .wdata     (b_wdata),
    .raddr     (b_raddr),
    .rdata     (b_rdata),
    .wr_collide(b_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input bit sel, input int port, input logic en,
                               input logic [4:0] addr, input logic [31:0] data);
    if (!sel) begin
      a_we[port]             = en;
      a_waddr[port*5 +: 5]   = addr;
      a_wdata[port*32 +: 32] = data;
    end else begin
      b_we[port]             = en;
      b_waddr[port*5 +: 5]   = addr;
      b_wdata[port*32 +: 32] = data;
    end
  endtask

  task automatic applyRead(input bit sel, input int port, input logic [4:0] addr);
    if (!sel) a_raddr[port*5 +: 5] = addr;
    else      b_raddr[port*5 +: 5] = addr;
  endtask

  task automatic clearWrites();
    a_we = '0; a_waddr = '0; a_wdata = '0;
    b_we = '0; b_waddr = '0; b_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0] addr;
    rst = 1'b0;
    clearWrites();
    a_raddr = '0;
    b_raddr = '0;
    #1 rst = 1'b1;
    #2;

    // Reset state, including a write that would otherwise bypass.
    applyStimulus(1, 0, 1'b1, 5'd7, 32'h0000_1234);
    applyRead(1, 1, 5'd7);
    #1;
    for (int j = 0; j < 4; j++) checkOutput("reset_a_rdata", a_rdata[j*32 +: 32], 32'h0);
    checkOutput("reset_a_col", {31'b0, a_col}, 32'h0);
    checkOutput("reset_b_col", {31'b0, b_col}, 32'h0);
    checkOutput("reset_b_bypass_blocked", b_rdata[32 +: 32], 32'h0);
    clearWrites();

    // A write presented during reset is discarded.
    applyStimulus(0, 0, 1'b1, 5'd1, 32'd99);
    tick();
    rst = 1'b0;
    clearWrites();
    applyRead(0, 0, 5'd1);
    #1;
    checkOutput("write_in_reset_dropped", a_rdata[0 +: 32], 32'h0);

    // No bypass: old value during the write cycle, new value afterwards.
    applyStimulus(0, 0, 1'b1, 5'd1, 32'd10);
    #1;
    checkOutput("nobyp_old_value", a_rdata[0 +: 32], 32'h0);
    tick();
    clearWrites();
    #1;
    checkOutput("nobyp_new_value", a_rdata[0 +: 32], 32'd10);

    // Bypass: write data visible on the matching read port before the edge.
    applyStimulus(1, 0, 1'b1, 5'd7, 32'h0000_1234);
    applyRead(1, 1, 5'd7);
    applyRead(1, 0, 5'd3);
    #1;
    checkOutput("bypass_hit", b_rdata[32 +: 32], 32'h0000_1234);
    checkOutput("bypass_other_port", b_rdata[0 +: 32], 32'h0);
    tick();
    clearWrites();
    #1;
    checkOutput("bypass_stored", b_rdata[32 +: 32], 32'h0000_1234);

    // Both write ports target r0 on both instances.
    applyStimulus(0, 0, 1'b1, 5'd0, 32'h0000_FFFF);
    applyStimulus(0, 1, 1'b1, 5'd0, 32'h0000_FFFF);
    applyStimulus(1, 0, 1'b1, 5'd0, 32'h0000_FFFF);
    applyStimulus(1, 1, 1'b1, 5'd0, 32'h0000_FFFF);
    applyRead(0, 0, 5'd0);
    applyRead(1, 0, 5'd0);
    #1;
    checkOutput("zero_a_same_cycle", a_rdata[0 +: 32], 32'h0);
    checkOutput("zero_b_bypass", b_rdata[0 +: 32], 32'h0000_FFFF);
    tick();
    clearWrites();
    #1;
    checkOutput("zero_a_stored", a_rdata[0 +: 32], 32'h0);
    checkOutput("zero_a_col", {31'b0, a_col}, 32'h0);
    checkOutput("zero_b_stored", b_rdata[0 +: 32], 32'h0000_FFFF);
    checkOutput("zero_b_col", {31'b0, b_col}, 32'h1);
    tick();
    #1;
    checkOutput("zero_b_col_clears", {31'b0, b_col}, 32'h0);

    // Collision on r3: higher-index port wins.
    applyStimulus(0, 0, 1'b1, 5'd3, 32'h0000_AAAA);
    applyStimulus(0, 1, 1'b1, 5'd3, 32'h0000_5555);
    applyStimulus(1, 0, 1'b1, 5'd3, 32'h0000_AAAA);
    applyStimulus(1, 1, 1'b1, 5'd3, 32'h0000_5555);
    applyRead(0, 1, 5'd3);
    applyRead(1, 0, 5'd3);
    #1;
    checkOutput("collide_a_before", a_rdata[32 +: 32], 32'h0);
    checkOutput("collide_b_bypass_prio", b_rdata[0 +: 32], 32'h0000_5555);
    tick();
    clearWrites();
    #1;
    checkOutput("collide_a_stored", a_rdata[32 +: 32], 32'h0000_5555);
    checkOutput("collide_a_col", {31'b0, a_col}, 32'h1);
    checkOutput("collide_b_stored", b_rdata[0 +: 32], 32'h0000_5555);
    checkOutput("collide_b_col", {31'b0, b_col}, 32'h1);
    tick();
    #1;
    checkOutput("collide_a_col_clears", {31'b0, a_col}, 32'h0);
    checkOutput("collide_b_col_clears", {31'b0, b_col}, 32'h0);

    // Sweep r1..r15 through port 1, then read four staggered addresses.
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(0, 1, 1'b1, 5'(i), 32'(10 * i));
      tick();
    end
    clearWrites();
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < 4; j++) applyRead(0, j, 5'(1 + ((g + 4 * j) % 15)));
      #1;
      for (int j = 0; j < 4; j++) begin
        addr = 5'(1 + ((g + 4 * j) % 15));
        checkOutput("sweep_read", a_rdata[j*32 +: 32], 32'(10 * int'(addr)));
      end
    end
    checkOutput("sweep_a_col", {31'b0, a_col}, 32'h0);

    // Asynchronous reset between edges clears the array and the flag.
    applyStimulus(0, 0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    applyStimulus(1, 1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    clearWrites();
    applyRead(0, 0, 5'd5);
    applyRead(1, 0, 5'd5);
    #1;
    checkOutput("pre_reset_a_r5", a_rdata[0 +: 32], 32'hDEAD_BEEF);
    checkOutput("pre_reset_b_r5", b_rdata[0 +: 32], 32'hDEAD_BEEF);
    checkOutput("pre_reset_b_col", {31'b0, b_col}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_a_r5", a_rdata[0 +: 32], 32'h0);
    checkOutput("async_reset_b_r5", b_rdata[0 +: 32], 32'h0);
    checkOutput("async_reset_b_col", {31'b0, b_col}, 32'h0);

    // First edge after reset release performs its write.
    rst = 1'b0;
    applyStimulus(0, 0, 1'b1, 5'd2, 32'h0000_0077);
    applyRead(0, 0, 5'd2);
    tick();
    clearWrites();
    #1;
    checkOutput("first_edge_write", a_rdata[0 +: 32], 32'h0000_0077);
    checkOutput("post_reset_b_r5", b_rdata[0 +: 32], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
